bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//  24-hour HH:MM:SS time-keeping core for the clock display. Divides the system clock to a 1 Hz tick,
//  keeps six BCD digits and provides a RUN / SET_HR / SET_MIN mode FSM driven by debounced button pulses.
//  Directly upstream of the six led7_decoder instances, one per 4-bit BCD output digit.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per 1 s tick; legal range is 2 or more. Simulation uses 4.
// PORTS
//  clk        in   1  system clock; the only clock, and every flop uses it
//  rst_n      in   1  asynchronous, active-low reset
//  btn_mode   in   1  single-cycle pulse from the debouncer; advances the mode
//  btn_inc    in   1  single-cycle pulse from the debouncer; increments the field being set
//  sec_lo     out  4  BCD seconds units, 0-9
//  sec_hi     out  4  BCD seconds tens, 0-5
//  min_lo     out  4  BCD minutes units, 0-9
//  min_hi     out  4  BCD minutes tens, 0-5
//  hr_lo      out  4  BCD hours units, 0-9 (0-3 when hr_hi=2)
//  hr_hi      out  4  BCD hours tens, 0-2
//  set_hr     out  1  high while the FSM is in SET_HR
//  set_min    out  1  high while the FSM is in SET_MIN
//  blink      out  1  toggles on every tick; display uses it to flash the digits being set
//  tick       out  1  1-cycle pulse when the prescaler wraps
// BEHAVIOUR
//  Reset: all digits=0 (00:00:00), FSM=RUN, prescaler=0, set_hr=0, set_min=0, blink=0, tick=0.
//  Prescaler: counts 0..TICK_DIV-1 and wraps to 0.
//   - tick is registered and is high for the cycle after the count is TICK_DIV-1.
//   - tick period is exactly TICK_DIV cycles.
//   - Prescaler runs in every mode.
//  All digit outputs are registered. An update is visible the cycle after the causing event.
//  RUN, on tick:
//   - seconds +1; 59 -> 00 with carry to minutes.
//   - minutes +1 on carry; 59 -> 00 with carry to hours.
//   - hours +1 on carry; 23 -> 00.
//   - 23:59:59 + tick -> 00:00:00 in a single cycle.
//  SET_HR / SET_MIN:
//   - Time is frozen: tick does not advance any digit. blink and tick keep running.
//   - btn_inc: selected field +1, modulo 24 (hours) or 60 (minutes).
//   - Wrap in a set mode produces no carry, so other fields are unchanged.
//  FSM: RUN -btn_mode-> SET_HR -btn_mode-> SET_MIN -btn_mode-> RUN.
//   - On the SET_MIN -> RUN transition, seconds clear to 00 and the prescaler clears to 0.
//   - The first tick after that transition comes TICK_DIV cycles later.
//  Button rules:
//   - btn_inc in RUN is ignored.
//   - btn_mode and btn_inc in the same cycle: the mode change wins and btn_inc is dropped.
//   - btn_inc coinciding with tick in a set mode: the increment is applied; tick has no effect.
//  Digit invariant: no output ever holds a non-BCD value or an illegal time (hours max 23, min/sec max 59).
//  rst_n low at any point, including mid-set, forces the reset state asynchronously.
// STRUCTURE
//  Shared package clock_pkg:
//   - mode_t enum {RUN=2'd0, SET_HR=2'd1, SET_MIN=2'd2}; encoding 2'd3 is illegal and recovers to RUN.
//   - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23, BCD_W=4.
//  Sub-module bcd_pair_counter (parameter MAX):
//   - Two-digit BCD counter with inc in, clr in, carry out, lo/hi out.
//   - Instantiated three times: seconds, minutes, hours.
//   - Hours rollover is 23 -> 00, which needs a compare on both digits, not only the units digit.
//  Top level: prescaler, mode FSM and the inc/carry steering.
// TESTING (TICK_DIV=4)
//  1. Reset release, RUN, 10 ticks -> 00:00:10; tick period is exactly 4 clk cycles.
//  2. Force 23:59:59, one tick -> 00:00:00 in a single cycle, with all three carries together.
//  3. btn_mode -> set_hr=1. 25 btn_inc pulses -> hours 01 (wraps at 23), minutes/seconds unchanged,
//     and ticks do not advance seconds.
//  4. SET_MIN at 59, btn_inc -> minutes 00 and hours unchanged. Then btn_mode -> RUN with seconds=00,
//     and the next tick comes 4 cycles later.
//  5. btn_mode and btn_inc in the same cycle in SET_HR -> FSM goes to SET_MIN and hours unchanged.
//     btn_inc in RUN -> no change.
//  6. rst_n pulsed low mid-SET_MIN at 12:34:56 -> immediate 00:00:00 with RUN, and set_hr, set_min
//     and blink all 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and limits for the HH:MM:SS time-keeping core.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
  localparam int BCD_W   = 4;

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps from MAX to 00 and flags the wrap as carry.
// The wrap compares both digits, so MAX=23 rolls over at 23 rather than at any x3.
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] lo,
  output logic [BCD_W-1:0] hi,
  output logic             carry
);

  localparam logic [BCD_W-1:0] MAX_LO = BCD_W'(MAX % 10);
  localparam logic [BCD_W-1:0] MAX_HI = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] NINE   = BCD_W'(9);

  logic at_max;

  assign at_max = (lo == MAX_LO) && (hi == MAX_HI);
  assign carry  = inc && at_max && !clr;

  // Digit pair: clear wins, otherwise step with units-to-tens ripple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      hi <= '0;
    end else if (clr) begin
      lo <= '0;
      hi <= '0;
    end else if (inc) begin
      if (at_max) begin
        lo <= '0;
        hi <= '0;
      end else if (lo == NINE) begin
        lo <= '0;
        hi <= hi + BCD_W'(1);
      end else begin
        lo <= lo + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS core: 1 Hz prescaler, RUN/SET_HR/SET_MIN mode FSM and
// steering of tick, carries and button increments into the three digit pairs.
//
// state   | meaning
// RUN     | time advances on every tick, btn_inc ignored
// SET_HR  | time frozen, btn_inc steps hours modulo 24
// SET_MIN | time frozen, btn_inc steps minutes modulo 60; leaving clears seconds and prescaler
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [BCD_W-1:0] sec_lo,
  output logic [BCD_W-1:0] sec_hi,
  output logic [BCD_W-1:0] min_lo,
  output logic [BCD_W-1:0] min_hi,
  output logic [BCD_W-1:0] hr_lo,
  output logic [BCD_W-1:0] hr_hi,
  output logic             set_hr,
  output logic             set_min,
  output logic             blink,
  output logic             tick
);

  localparam int              CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

  mode_t         mode, mode_nxt;
  logic [CW-1:0] cnt;
  logic          run, exit_set;
  logic          sec_inc, min_inc, hr_inc;
  logic          sec_carry, min_carry, unused_hr_carry;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode <= RUN;
    else        mode <= mode_nxt;
  end

  // Mode sequencing; the unused encoding falls back to RUN.
  always_comb begin
    mode_nxt = mode;
    case (mode)
      RUN:     if (btn_mode) mode_nxt = SET_HR;
      SET_HR:  if (btn_mode) mode_nxt = SET_MIN;
      SET_MIN: if (btn_mode) mode_nxt = RUN;
      default: mode_nxt = RUN;
    endcase
  end

  assign run      = (mode == RUN);
  assign exit_set = (mode == SET_MIN) && btn_mode;
  assign set_hr   = (mode == SET_HR);
  assign set_min  = (mode == SET_MIN);

  // Prescaler and registered tick; leaving SET_MIN restarts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (exit_set) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  // Blink flips once per tick in every mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink <= 1'b0;
    else        blink <= blink ^ tick;
  end

  // Carries only ripple in RUN; in set modes a wrap stays inside its own field.
  assign sec_inc = run && tick;
  assign min_inc = run ? sec_carry : (set_min && btn_inc && !btn_mode);
  assign hr_inc  = run ? min_carry : (set_hr && btn_inc && !btn_mode);

  bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (exit_set),
    .lo    (sec_lo),
    .hi    (sec_hi),
    .carry (sec_carry)
  );

  bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .lo    (min_lo),
    .hi    (min_hi),
    .carry (min_carry)
  );

  bcd_pair_counter #(.MAX(HR_MAX)) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hr_inc),
    .clr   (1'b0),
    .lo    (hr_lo),
    .hi    (hr_hi),
    .carry (unused_hr_carry)
  );

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter with TICK_DIV=4: time-of-day model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_bcd_time_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic       set_hr, set_min, blink, tick;

  int n_vec = 0;
  int n_err = 0;

  // model state: time of day as plain integers
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_pc = 0;
  bit m_tick = 0, m_blink = 0;

  bcd_time_counter #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_lo   (sec_lo),
    .sec_hi   (sec_hi),
    .min_lo   (min_lo),
    .min_hi   (min_hi),
    .hr_lo    (hr_lo),
    .hr_hi    (hr_hi),
    .set_hr   (set_hr),
    .set_min  (set_min),
    .blink    (blink),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_pc = 0; m_tick = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit bm, input bit bi);
    bit t;
    bit leave;
    int tot;
    t = m_tick;
    leave = (m_mode == 2) && bm;
    if (m_mode == 0 && t) begin
      tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = tot / 3600;
      m_m = (tot / 60) % 60;
      m_s = tot % 60;
    end
    if (!bm && bi) begin
      if (m_mode == 1) m_h = (m_h + 1) % 24;
      else if (m_mode == 2) m_m = (m_m + 1) % 60;
    end
    if (bm) begin
      if (leave) m_s = 0;
      m_mode = (m_mode + 1) % 3;
    end
    m_blink = m_blink ^ t;
    if (leave) begin
      m_tick = 0;
      m_pc = 0;
    end else begin
      m_tick = (m_pc == TD - 1);
      m_pc = (m_pc + 1) % TD;
    end
  endtask

  // Advance the model on every active edge; reset is asynchronous like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step(btn_mode, btn_inc);
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    chk("sec_lo", sec_lo, m_s % 10);
    chk("sec_hi", sec_hi, m_s / 10);
    chk("min_lo", min_lo, m_m % 10);
    chk("min_hi", min_hi, m_m / 10);
    chk("hr_lo", hr_lo, m_h % 10);
    chk("hr_hi", hr_hi, m_h / 10);
    chk("set_hr", set_hr, m_mode == 1);
    chk("set_min", set_min, m_mode == 2);
    chk("blink", blink, m_blink);
    chk("tick", tick, m_tick);
  end

  task automatic expect_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hr"}, hr_hi * 10 + hr_lo, h);
    chk({tag, "_min"}, min_hi * 10 + min_lo, m);
    chk({tag, "_sec"}, sec_hi * 10 + sec_lo, s);
  endtask

  task automatic pulse(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc = bi;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
  endtask

  // Wait for the next tick pulse; ncyc is the number of cycles it took.
  task automatic wait_tick(output int ncyc);
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (!tick && ncyc < 16);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic ticks(input int n);
    int c;
    for (int i = 0; i < n; i++) wait_tick(c);
    @(negedge clk);
  endtask

  initial begin
    int c;
    int w;
    repeat (3) @(negedge clk);
    expect_time("reset", 0, 0, 0);
    chk("reset_set_hr", set_hr, 0);
    chk("reset_set_min", set_min, 0);
    chk("reset_blink", blink, 0);
    chk("reset_tick", tick, 0);
    rst_n = 1'b1;

    // 1: ten ticks in RUN, period of four cycles
    wait_tick(c);
    for (int i = 1; i < 10; i++) begin
      wait_tick(c);
      chk("tick_period", c, 4);
    end
    @(negedge clk);
    expect_time("t1", 0, 0, 10);

    // 2: set 23:59, run to 23:59:59, then a single-cycle full rollover
    pulse(1, 0);
    repeat (23) pulse(0, 1);
    pulse(1, 0);
    repeat (59) pulse(0, 1);
    expect_time("t2_set", 23, 59, 10);
    pulse(1, 0);
    expect_time("t2_run", 23, 59, 0);
    ticks(59);
    expect_time("t2_pre", 23, 59, 59);
    ticks(1);
    expect_time("t2_wrap", 0, 0, 0);
    ticks(3);
    expect_time("t2_run3", 0, 0, 3);

    // 3: hours wrap in SET_HR, time frozen across ticks
    pulse(1, 0);
    chk("t3_set_hr", set_hr, 1);
    repeat (25) pulse(0, 1);
    expect_time("t3_inc", 1, 0, 3);
    ticks(3);
    expect_time("t3_frozen", 1, 0, 3);

    // 4: minutes wrap without carry, exit clears seconds and restarts the prescaler
    pulse(1, 0);
    chk("t4_set_min", set_min, 1);
    repeat (59) pulse(0, 1);
    expect_time("t4_m59", 1, 59, 3);
    pulse(0, 1);
    expect_time("t4_wrap", 1, 0, 3);
    pulse(1, 0);
    expect_time("t4_exit", 1, 0, 0);
    chk("t4_run_set_min", set_min, 0);
    wait_tick(c);
    chk("t4_first_tick", c, 4);

    // 5: mode beats inc in the same cycle; inc ignored in RUN
    pulse(1, 0);
    chk("t5_set_hr", set_hr, 1);
    pulse(1, 1);
    chk("t5_set_min", set_min, 1);
    chk("t5_hr_kept", hr_hi * 10 + hr_lo, 1);
    pulse(1, 0);
    pulse(0, 1);
    expect_time("t5_run_inc", 1, 0, 0);

    // 6: asynchronous reset in the middle of SET_MIN at 12:34:56
    w = 0;
    while (!(sec_hi == 4'd5 && sec_lo == 4'd6) && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("t6_reach56", w < 400, 1);
    pulse(1, 0);
    repeat (11) pulse(0, 1);
    pulse(1, 0);
    repeat (34) pulse(0, 1);
    expect_time("t6_set", 12, 34, 56);
    chk("t6_in_set_min", set_min, 1);
    #2 rst_n = 1'b0;
    #1;
    expect_time("t6_rst", 0, 0, 0);
    chk("t6_rst_set_hr", set_hr, 0);
    chk("t6_rst_set_min", set_min, 0);
    chk("t6_rst_blink", blink, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
